// File: rtl/merge_radio_tx_pkg.sv
// merge_radio_pkg: line symbol encodings, serializer states and source tags shared by merge_radio_tx.
package merge_radio_pkg;
    // {Plus, Minus}; 2'b11 is never driven
    localparam logic [1:0] SYM_IDLE  = 2'b00;
    localparam logic [1:0] SYM_MARK  = 2'b10;
    localparam logic [1:0] SYM_SPACE = 2'b01;

    localparam logic TAG_RADIO = 1'b1;
    localparam logic TAG_WIRED = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TAG,
        ST_DATA,
        ST_PARITY,
        ST_GAP
    } state_t;

    function automatic logic [1:0] bit_sym(input logic b);
        return b ? SYM_MARK : SYM_SPACE;
    endfunction
endpackage

// File: rtl/merge_radio_tx_line_skew_delay.sv
// line_skew_delay: DEPTH-stage shift line for the differential symbol pair.
//   clk, rst      : clock, asynchronous active-high reset (stages cleared to IDLE)
//   sym_in        : symbol entering stage 0
//   sym_out       : last stage, drives the pins
//   active        : some stage holds a non-IDLE symbol
module line_skew_delay
    import merge_radio_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] sym_in,
    output logic [1:0] sym_out,
    output logic       active
);
    logic [1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= SYM_IDLE;
        end else begin
            stage[0] <= sym_in;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    always_comb begin
        active = 1'b0;
        for (int i = 0; i < DEPTH; i++) active = active | (stage[i] != SYM_IDLE);
    end

    assign sym_out = stage[DEPTH-1];
endmodule

// File: rtl/merge_radio_tx.sv
// merge_radio_tx: round-robin merge of radio and wired words into tagged, even-parity differential frames.
//   Clock, Reset                    : clock, asynchronous active-high reset
//   Radio_Data/Valid/Ready          : radio source handshake, Ready = holding register empty
//   Wired_Data/Valid/Ready          : wired source handshake, Ready = holding register empty
//   Transmit_Plus, Transmit_Minus   : differential symbol pair after the skew-delay line
//   Busy                            : word held, frame in progress, or symbol still in the delay line
module merge_radio_tx
    import merge_radio_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DELAY    = 3,
    parameter int IDLE_GAP = 1
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] Radio_Data,
    input  logic              Radio_Valid,
    output logic              Radio_Ready,
    input  logic [DATA_W-1:0] Wired_Data,
    input  logic              Wired_Valid,
    output logic              Wired_Ready,
    output logic              Transmit_Plus,
    output logic              Transmit_Minus,
    output logic              Busy
);
    localparam int CW = $clog2((DATA_W > IDLE_GAP ? DATA_W : IDLE_GAP) + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);
    localparam logic [CW-1:0] LAST_GAP = CW'(IDLE_GAP - 1);

    logic              ready_en, r_full, w_full, ptr_w, grant, pick_w, sel_tag, tag, par, line_active;
    logic [DATA_W-1:0] r_data, w_data, sel_data, shreg;
    logic [CW-1:0]     cnt, cnt_n;
    logic [1:0]        sym;
    state_t            state, state_n;

    // Ready stays low until the first edge after reset release
    assign Radio_Ready = ready_en && !r_full;
    assign Wired_Ready = ready_en && !w_full;

    // Granting in the last GAP cycle lets the next START follow with no bubble
    assign grant    = (state == ST_IDLE || (state == ST_GAP && cnt == LAST_GAP)) && (r_full || w_full);
    assign pick_w   = w_full && (!r_full || ptr_w);
    assign sel_data = pick_w ? w_data : r_data;
    assign sel_tag  = pick_w ? TAG_WIRED : TAG_RADIO;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            ready_en <= 1'b0;
            r_full   <= 1'b0;
            w_full   <= 1'b0;
            r_data   <= '0;
            w_data   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (Radio_Valid && Radio_Ready) begin
                r_full <= 1'b1;
                r_data <= Radio_Data;
            end else if (grant && !pick_w) begin
                r_full <= 1'b0;
            end
            if (Wired_Valid && Wired_Ready) begin
                w_full <= 1'b1;
                w_data <= Wired_Data;
            end else if (grant && pick_w) begin
                w_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            tag   <= 1'b0;
            par   <= 1'b0;
            ptr_w <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (grant) begin
                shreg <= sel_data;
                tag   <= sel_tag;
                par   <= sel_tag ^ (^sel_data);
                ptr_w <= !pick_w;
            end else if (state == ST_DATA) begin
                shreg <= shreg >> 1;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE:   if (grant) state_n = ST_START;
            ST_START:  state_n = ST_TAG;
            ST_TAG: begin
                state_n = ST_DATA;
                cnt_n   = '0;
            end
            ST_DATA: begin
                if (cnt == LAST_BIT) state_n = ST_PARITY;
                else cnt_n = cnt + 1'b1;
            end
            ST_PARITY: begin
                state_n = ST_GAP;
                cnt_n   = '0;
            end
            ST_GAP: begin
                if (grant) state_n = ST_START;
                else if (cnt == LAST_GAP) state_n = ST_IDLE;
                else cnt_n = cnt + 1'b1;
            end
            default:   state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        sym = SYM_IDLE;
        case (state)
            ST_START:  sym = SYM_MARK;
            ST_TAG:    sym = bit_sym(tag);
            ST_DATA:   sym = bit_sym(shreg[0]);
            ST_PARITY: sym = bit_sym(par);
            default:   sym = SYM_IDLE;
        endcase
    end

    line_skew_delay #(.DEPTH(DELAY)) u_skew (
        .clk    (Clock),
        .rst    (Reset),
        .sym_in (sym),
        .sym_out({Transmit_Plus, Transmit_Minus}),
        .active (line_active)
    );

    assign Busy = r_full || w_full || state != ST_IDLE || line_active;
endmodule

// File: tb/tb_merge_radio_tx.sv
// tb_merge_radio_tx: scoreboard bench for merge_radio_tx with a transaction-level line model.
module tb_merge_radio_tx;
    localparam int DW = 8;
    localparam int DL = 3;
    localparam int IG = 1;
    localparam logic [1:0] MARK = 2'b10;
    localparam logic [1:0] SPACE = 2'b01;

    typedef struct {
        logic          tag;
        logic [DW-1:0] data;
        int            start;
    } exp_t;

    logic clk = 1'b0;
    logic Reset = 1'b1;
    logic [DW-1:0] Radio_Data = '0, Wired_Data = '0;
    logic Radio_Valid = 1'b0, Wired_Valid = 1'b0;
    logic Radio_Ready, Wired_Ready, Transmit_Plus, Transmit_Minus, Busy;

    merge_radio_tx #(.DATA_W(DW), .DELAY(DL), .IDLE_GAP(IG)) dut (
        .Clock         (clk),
        .Reset         (Reset),
        .Radio_Data    (Radio_Data),
        .Radio_Valid   (Radio_Valid),
        .Radio_Ready   (Radio_Ready),
        .Wired_Data    (Wired_Data),
        .Wired_Valid   (Wired_Valid),
        .Wired_Ready   (Wired_Ready),
        .Transmit_Plus (Transmit_Plus),
        .Transmit_Minus(Transmit_Minus),
        .Busy          (Busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // stimulus queues and driver state
    logic [DW-1:0] rq[$], wq[$];
    bit rand_idle = 1'b0;
    bit r_fire = 1'b0, w_fire = 1'b0;

    // reference model: one held word per source, the line is free again IDLE_GAP
    // cycles after the parity symbol leaves the serializer
    exp_t expq[$];
    bit m_ready_en = 1'b0, h_r = 1'b0, h_w = 1'b0, m_ptr_w = 1'b0;
    logic [DW-1:0] hd_r, hd_w;
    int free_at = 0, busy_until = -100;

    // pin monitor
    bit mon_on = 1'b0;
    int mon_idx = 0;
    logic m_tag, m_par;
    logic [DW-1:0] m_data;

    always @(negedge clk) begin
        logic [1:0] p;
        bit mr_r, mr_w, pw;
        p = {Transmit_Plus, Transmit_Minus};
        if (Reset) begin
            chk("reset_pins", p, 0);
            chk("reset_radio_ready", Radio_Ready, 0);
            chk("reset_wired_ready", Wired_Ready, 0);
            chk("reset_busy", Busy, 0);
            m_ready_en = 1'b0; h_r = 1'b0; h_w = 1'b0; m_ptr_w = 1'b0;
            free_at = 0; busy_until = -100;
            expq.delete();
            mon_on = 1'b0;
            r_fire = 1'b0; w_fire = 1'b0;
        end else begin
            if (!mon_on) begin
                if (p != 2'b00) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_symbol", p, 0);
                    end else begin
                        chk("start_symbol", p, MARK);
                        chk("start_cycle", cyc, expq[0].start);
                        mon_on = 1'b1; mon_idx = 1; m_data = '0;
                    end
                end else if (expq.size() > 0 && cyc > expq[0].start) begin
                    chk("frame_missing_pins", p, MARK);
                    void'(expq.pop_front());
                end
            end else begin
                if (mon_idx <= DW + 2) begin
                    chk("frame_symbol_legal", (p == MARK || p == SPACE), 1);
                    if (mon_idx == 1) m_tag = (p == MARK);
                    else if (mon_idx <= DW + 1) m_data[mon_idx-2] = (p == MARK);
                    else m_par = (p == MARK);
                    mon_idx++;
                end else begin
                    chk("gap_idle", p, 0);
                    chk("frame_tag", m_tag, expq[0].tag);
                    chk("frame_data", m_data, expq[0].data);
                    chk("frame_parity", m_par, expq[0].tag ^ (^expq[0].data));
                    void'(expq.pop_front());
                    mon_on = 1'b0;
                end
            end
            mr_r = m_ready_en && !h_r;
            mr_w = m_ready_en && !h_w;
            chk("radio_ready", Radio_Ready, mr_r);
            chk("wired_ready", Wired_Ready, mr_w);
            chk("busy", Busy, (h_r || h_w || cyc <= busy_until));
            r_fire = Radio_Valid && Radio_Ready;
            w_fire = Wired_Valid && Wired_Ready;
            if (cyc >= free_at && (h_r || h_w)) begin
                pw = h_w && (!h_r || m_ptr_w);
                expq.push_back('{tag: !pw, data: pw ? hd_w : hd_r, start: cyc + 1 + DL});
                if (pw) h_w = 1'b0; else h_r = 1'b0;
                m_ptr_w = !pw;
                free_at = cyc + DW + 3 + IG;
                busy_until = cyc + DW + 3 + (DL > IG ? DL : IG);
            end
            if (Radio_Valid && mr_r) begin h_r = 1'b1; hd_r = Radio_Data; end
            if (Wired_Valid && mr_w) begin h_w = 1'b1; hd_w = Wired_Data; end
            m_ready_en = 1'b1;
        end
    end

    task automatic tick();
        bit hold;
        @(posedge clk);
        #1;
        if (r_fire && rq.size() > 0) void'(rq.pop_front());
        if (w_fire && wq.size() > 0) void'(wq.pop_front());
        hold = Radio_Valid && !r_fire;
        Radio_Valid = rq.size() > 0 && (hold || !rand_idle || $urandom_range(0, 1) == 1);
        if (rq.size() > 0) Radio_Data = rq[0];
        hold = Wired_Valid && !w_fire;
        Wired_Valid = wq.size() > 0 && (hold || !rand_idle || $urandom_range(0, 1) == 1);
        if (wq.size() > 0) Wired_Data = wq[0];
    endtask

    task automatic drain();
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rq.size() == 0 && wq.size() == 0 && expq.size() == 0 && !mon_on && !Busy) return;
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: busy=%0d rq=%0d wq=%0d expected_frames=%0d", Busy, rq.size(), wq.size(), expq.size());
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    initial begin
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        tick();
        rq.push_back(8'hA5);
        drain();
        wq.push_back(8'h00);
        drain();
        do_reset();
        rq.push_back(8'h01);
        wq.push_back(8'hFF);
        drain();
        rq.push_back(8'h11);
        rq.push_back(8'h22);
        rq.push_back(8'h33);
        drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rq.push_back(8'(8'h40 + i));
            wq.push_back(8'(8'hC0 + i));
        end
        drain();
        // abort a frame while data bit 3 is on the pins
        rq.push_back(8'hA5);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 50 && !seen; i++) begin
                tick();
                seen = mon_on;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL abort_frame_start: frame never appeared on the pins");
            end
        end
        repeat (4) tick();
        Reset = 1'b1;
        #1;
        chk("abort_pins", {Transmit_Plus, Transmit_Minus}, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_radio_ready", Radio_Ready, 0);
        tick();
        tick();
        Reset = 1'b0;
        tick();
        tick();
        rq.push_back(8'h3C);
        drain();
        rand_idle = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rq.push_back(8'($urandom));
            wq.push_back(8'($urandom));
        end
        drain();
        repeat (5) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
